fb_pixel_writer: RTL and testbench



---
 rtl/fb_pkg.sv | 18 +
 rtl/fb_pixel_writer_if.sv | 28 ++
 rtl/fb_pixel_writer.sv | 132 +++++++++++++
 tb/tb_fb_pixel_writer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared constants and types for the 800x480 1-bpp frame buffer.
// Used by both the pixel writer and the read side of the buffer.
package fb_pkg;

    localparam int unsigned H_PIXELS     = 800;
    localparam int unsigned V_PIXELS     = 480;
    localparam int unsigned WORD_BITS    = 16;
    localparam int unsigned ADDR_W       = 16;
    localparam int unsigned BIT_W        = $clog2(WORD_BITS);
    localparam int unsigned FB_WORDS     = H_PIXELS * V_PIXELS / WORD_BITS;
    localparam int unsigned FB_LAST_ADDR = FB_WORDS - 1;

    typedef enum logic {
        RUN,
        CLEAR
    } fb_state_e;

endpackage

// File: rtl/fb_pixel_writer_if.sv
// Pixel stream, clear command and frame-buffer write port of fb_pixel_writer.
// master = pixel source / controller, slave = the writer block.
interface fb_pixel_writer_if;
    import fb_pkg::*;

    logic                 pix_valid;
    logic                 pix_ready;
    logic                 pix_data;
    logic                 pix_sof;
    logic                 clear_req;
    logic                 clear_value;
    logic                 busy;
    logic                 frame_done;
    logic [ADDR_W-1:0]    write_address;
    logic [WORD_BITS-1:0] data_in;
    logic                 load;

    modport master (
        output pix_valid, pix_data, pix_sof, clear_req, clear_value,
        input  pix_ready, busy, frame_done, write_address, data_in, load
    );

    modport slave (
        input  pix_valid, pix_data, pix_sof, clear_req, clear_value,
        output pix_ready, busy, frame_done, write_address, data_in, load
    );

endinterface

// File: rtl/fb_pixel_writer.sv
// Packs a raster stream of 1-bit pixels into 16-bit frame-buffer words and
// offers a bulk clear; the packer and the clear share one word-address counter.
module fb_pixel_writer
    import fb_pkg::*;
#(
    parameter int unsigned H_PIXELS = fb_pkg::H_PIXELS,
    parameter int unsigned V_PIXELS = fb_pkg::V_PIXELS
) (
    input  logic               clk,
    input  logic               reset,
    fb_pixel_writer_if.slave   bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_PIXELS * V_PIXELS / WORD_BITS - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_BITS - 1);

    fb_state_e            state_q, state_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [ADDR_W-1:0]    word_q, word_d;
    logic [WORD_BITS-1:0] shift_q, shift_d;
    logic                 clear_val_q, clear_val_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [WORD_BITS-1:0] data_q, data_d;
    logic                 load_q, load_d;
    logic                 done_q, done_d;

    logic                 accept;
    logic [BIT_W-1:0]     bit_idx;
    logic [ADDR_W-1:0]    word_idx;
    logic [WORD_BITS-1:0] word_next;

    assign bus.pix_ready     = (state_q == RUN) && !bus.clear_req;
    assign accept            = bus.pix_valid && bus.pix_ready;
    assign bus.busy          = (state_q == CLEAR);
    assign bus.load          = load_q;
    assign bus.write_address = addr_q;
    assign bus.data_in       = data_q;
    assign bus.frame_done    = done_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        bit_d       = bit_q;
        word_d      = word_q;
        shift_d     = shift_q;
        clear_val_d = clear_val_q;
        addr_d      = addr_q;
        data_d      = data_q;
        load_d      = 1'b0;
        done_d      = 1'b0;

        // A start-of-frame pixel restarts at word 0, bit 0 with an empty word.
        bit_idx            = bus.pix_sof ? '0 : bit_q;
        word_idx           = bus.pix_sof ? '0 : word_q;
        word_next          = bus.pix_sof ? '0 : shift_q;
        word_next[bit_idx] = bus.pix_data;

        case (state_q)
            RUN: begin
                if (bus.clear_req) begin
                    // Address 0 is issued on entry so the clear starts the next cycle.
                    state_d     = CLEAR;
                    clear_val_d = bus.clear_value;
                    word_d      = '0;
                    load_d      = 1'b1;
                    addr_d      = '0;
                    data_d      = {WORD_BITS{bus.clear_value}};
                end else if (accept) begin
                    if (bit_idx == LAST_BIT) begin
                        load_d  = 1'b1;
                        addr_d  = word_idx;
                        data_d  = word_next;
                        shift_d = '0;
                        bit_d   = '0;
                        if (word_idx == LAST_ADDR) begin
                            done_d = 1'b1;
                            word_d = '0;
                        end else begin
                            word_d = word_idx + ADDR_W'(1);
                        end
                    end else begin
                        shift_d = word_next;
                        bit_d   = bit_idx + BIT_W'(1);
                        word_d  = word_idx;
                    end
                end
            end

            CLEAR: begin
                if (word_q == LAST_ADDR) begin
                    state_d = RUN;
                    word_d  = '0;
                    bit_d   = '0;
                    shift_d = '0;
                end else begin
                    word_d = word_q + ADDR_W'(1);
                    load_d = 1'b1;
                    addr_d = word_q + ADDR_W'(1);
                    data_d = {WORD_BITS{clear_val_q}};
                end
            end

            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
        if (reset) begin
            state_q     <= RUN;
            bit_q       <= '0;
            word_q      <= '0;
            shift_q     <= '0;
            clear_val_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            load_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            word_q      <= word_d;
            shift_q     <= shift_d;
            clear_val_q <= clear_val_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            load_q      <= load_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Self-checking bench for fb_pixel_writer: a full-size instance plus a 32x2 instance
// (same inputs, own reset) so frame wrap and random clears fit a short run.
module tb_fb_pixel_writer;
    import fb_pkg::*;

    localparam int S_H = 32;
    localparam int S_V = 2;

    typedef struct {
        int unsigned  addr;
        logic [15:0]  data;
        logic         fd;
        int           cyc;
    } wr_t;

    typedef struct {
        logic [15:0] bits;
        logic        sof;
        logic [15:0] exp_addr;
        logic [15:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst_b, rst_s;
    logic pix_valid, pix_data, pix_sof, clear_req, clear_value;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   load_cnt0 = 0, load_cnt1 = 0, fd_cnt1 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fb_pixel_writer_if bus();
    fb_pixel_writer_if bus_s();

    assign bus.pix_valid     = pix_valid;
    assign bus.pix_data      = pix_data;
    assign bus.pix_sof       = pix_sof;
    assign bus.clear_req     = clear_req;
    assign bus.clear_value   = clear_value;
    assign bus_s.pix_valid   = pix_valid;
    assign bus_s.pix_data    = pix_data;
    assign bus_s.pix_sof     = pix_sof;
    assign bus_s.clear_req   = clear_req;
    assign bus_s.clear_value = clear_value;

    fb_pixel_writer dut (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus)
    );

    fb_pixel_writer #(.H_PIXELS(S_H), .V_PIXELS(S_V)) dut_s (
        .clk   (clk),
        .reset (rst_s),
        .bus   (bus_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: pixel index n, pending word, remaining clear cycles.
    int         m_n[2];
    logic [15:0] m_cur[2];
    int         m_clr[2];
    bit         m_acc[2];
    wr_t        exp_q0[$];
    wr_t        exp_q1[$];

    function automatic int frame_pix(input int id);
        return (id == 0) ? int'(H_PIXELS * V_PIXELS) : S_H * S_V;
    endfunction

    function automatic void push(input int id, input wr_t r);
        if (id == 0) exp_q0.push_back(r);
        else         exp_q1.push_back(r);
    endfunction

    function automatic void model_step(input int id, input logic rst, input int now);
        wr_t r;
        m_acc[id] = 1'b0;
        if (rst) begin
            m_n[id]   = 0;
            m_cur[id] = '0;
            m_clr[id] = 0;
            if (id == 0) exp_q0.delete();
            else         exp_q1.delete();
        end else if (m_clr[id] > 0) begin
            m_clr[id]--;
            if (m_clr[id] == 0) begin
                m_n[id]   = 0;
                m_cur[id] = '0;
            end
        end else if (clear_req) begin
            m_clr[id] = frame_pix(id) / 16;
            for (int k = 0; k < m_clr[id]; k++) begin
                r.addr = k;
                r.data = {16{clear_value}};
                r.fd   = 1'b0;
                r.cyc  = now + k;
                push(id, r);
            end
        end else if (pix_valid) begin
            m_acc[id] = 1'b1;
            if (pix_sof) begin
                m_n[id]   = 0;
                m_cur[id] = '0;
            end
            m_cur[id][m_n[id] % 16] = pix_data;
            m_n[id]++;
            if (m_n[id] % 16 == 0) begin
                r.addr = m_n[id] / 16 - 1;
                r.data = m_cur[id];
                r.fd   = (m_n[id] == frame_pix(id));
                r.cyc  = now;
                push(id, r);
                if (r.fd) m_n[id] = 0;
            end
        end
    endfunction

    // Write-port monitors: every load must match the next expected write in the same cycle.
    always @(negedge clk) begin
        if (exp_q0.size() > 0 && exp_q0[0].cyc == cyc) begin
            check("load0", bus.load, 1);
            check("addr0", bus.write_address, exp_q0[0].addr);
            check("data0", bus.data_in, exp_q0[0].data);
            check("frame_done0", bus.frame_done, exp_q0[0].fd);
            void'(exp_q0.pop_front());
        end else begin
            if (bus.load === 1'b1)       check("load0 unexpected", bus.load, 0);
            if (bus.frame_done === 1'b1) check("frame_done0 unexpected", bus.frame_done, 0);
        end
        if (bus.load === 1'b1) load_cnt0 <= load_cnt0 + 1;
    end

    always @(negedge clk) begin
        if (exp_q1.size() > 0 && exp_q1[0].cyc == cyc) begin
            check("load1", bus_s.load, 1);
            check("addr1", bus_s.write_address, exp_q1[0].addr);
            check("data1", bus_s.data_in, exp_q1[0].data);
            check("frame_done1", bus_s.frame_done, exp_q1[0].fd);
            void'(exp_q1.pop_front());
        end else begin
            if (bus_s.load === 1'b1)       check("load1 unexpected", bus_s.load, 0);
            if (bus_s.frame_done === 1'b1) check("frame_done1 unexpected", bus_s.frame_done, 0);
        end
        if (bus_s.load === 1'b1)       load_cnt1 <= load_cnt1 + 1;
        if (bus_s.frame_done === 1'b1) fd_cnt1   <= fd_cnt1 + 1;
    end

    // One clock of stimulus; called #1 after a rising edge and returns #1 after the next.
    task automatic step(input logic v, input logic d, input logic s, input logic c, input logic cv);
        pix_valid   = v;
        pix_data    = d;
        pix_sof     = s;
        clear_req   = c;
        clear_value = cv;
        @(negedge clk);
        check("pix_ready0", bus.pix_ready, (m_clr[0] == 0) && !c);
        check("busy0", bus.busy, m_clr[0] > 0);
        check("pix_ready1", bus_s.pix_ready, (m_clr[1] == 0) && !c);
        check("busy1", bus_s.busy, m_clr[1] > 0);
        @(posedge clk);
        #1;
        model_step(0, rst_b, cyc);
        model_step(1, rst_s, cyc);
    endtask

    task automatic send_pixel(input logic d, input logic s);
        bit got = 1'b0;
        for (int t = 0; t < 64 && !got; t++) begin
            step(1'b1, d, s, 1'b0, 1'b0);
            got = m_acc[0];
        end
        if (!got) check("pixel accept timeout", bus.pix_ready, 1);
    endtask

    task automatic send_word(input logic [15:0] bits, input logic sof);
        for (int i = 0; i < 16; i++) send_pixel(bits[i], sof && (i == 0));
    endtask

    task automatic finish_clear(input int id);
        for (int t = 0; t < 30000 && m_clr[id] > 0; t++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (m_clr[id] > 0) check("clear timeout", bus.busy, 0);
    endtask

    vec_t vecs[6];

    initial begin
        int lc;
        int fc;
        logic pv, pd, ps;

        vecs[0] = '{bits: 16'hA5C3, sof: 1'b1, exp_addr: 16'd0, exp_data: 16'hA5C3};
        vecs[1] = '{bits: 16'h0001, sof: 1'b0, exp_addr: 16'd1, exp_data: 16'h0001};
        vecs[2] = '{bits: 16'h8000, sof: 1'b0, exp_addr: 16'd2, exp_data: 16'h8000};
        vecs[3] = '{bits: 16'hFFFF, sof: 1'b0, exp_addr: 16'd3, exp_data: 16'hFFFF};
        vecs[4] = '{bits: 16'h0000, sof: 1'b0, exp_addr: 16'd4, exp_data: 16'h0000};
        vecs[5] = '{bits: 16'h1234, sof: 1'b1, exp_addr: 16'd0, exp_data: 16'h1234};

        pix_valid = 0; pix_data = 0; pix_sof = 0; clear_req = 0; clear_value = 0;
        rst_b = 1; rst_s = 1;
        repeat (2) @(posedge clk);
        #1;
        model_step(0, 1'b1, cyc);
        model_step(1, 1'b1, cyc);
        rst_b = 0; rst_s = 0;
        check("reset load", bus.load, 0);
        check("reset addr", bus.write_address, 0);
        check("reset data", bus.data_in, 0);
        check("reset busy", bus.busy, 0);
        check("reset frame_done", bus.frame_done, 0);
        check("reset pix_ready", bus.pix_ready, 1);

        // Table of single words: load one cycle after the 16th handshake.
        foreach (vecs[i]) begin
            send_word(vecs[i].bits, vecs[i].sof);
            check($sformatf("vec%0d load", i), bus.load, 1);
            check($sformatf("vec%0d addr", i), bus.write_address, vecs[i].exp_addr);
            check($sformatf("vec%0d data", i), bus.data_in, vecs[i].exp_data);
        end

        // Partial word discarded by start-of-frame.
        send_word(16'h0F0F, 1'b1);
        for (int i = 0; i < 4; i++) send_pixel(1'b1, 1'b0);
        send_word(16'hFFFF, 1'b1);
        check("sof restart addr", bus.write_address, 0);
        check("sof restart data", bus.data_in, 16'hFFFF);

        // Full frame on the small instance, then the next word lands at address 0.
        fc = fd_cnt1;
        lc = load_cnt1;
        send_word(16'h1111, 1'b1);
        send_word(16'h2222, 1'b0);
        send_word(16'h4444, 1'b0);
        send_word(16'h8888, 1'b0);
        check("small frame_done", bus_s.frame_done, 1);
        check("small last addr", bus_s.write_address, 3);
        send_word(16'h5A5A, 1'b0);
        check("small wrap load", bus_s.load, 1);
        check("small wrap addr", bus_s.write_address, 0);
        check("small frame_done count", fd_cnt1 - fc, 1);
        check("small load count", load_cnt1 - lc, 5);

        // Clear with value 1 while a pixel is offered and held.
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        lc = load_cnt0;
        check("clear busy", bus.busy, 1);
        check("clear first load", bus.load, 1);
        check("clear first addr", bus.write_address, 0);
        check("clear first data", bus.data_in, 16'hFFFF);
        for (int t = 0; t < 30000 && m_clr[0] > 0; t++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("clear load count", load_cnt0 - lc, 24000);
        check("clear end busy", bus.busy, 0);
        check("clear end load", bus.load, 0);
        check("clear end addr", bus.write_address, 23999);

        // Flush then clear on consecutive cycles; clear_req held high during CLEAR.
        send_word(16'h3C3C, 1'b1);
        check("flush load", bus.load, 1);
        check("flush data", bus.data_in, 16'h3C3C);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("clear after flush load", bus.load, 1);
        check("clear after flush addr", bus.write_address, 0);
        check("clear after flush data", bus.data_in, 16'h0000);
        repeat (5) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("held clear_req addr", bus.write_address, 5);
        finish_clear(0);
        check("held clear end busy", bus.busy, 0);

        // Reset in the middle of a clear.
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (1000) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mid clear addr", bus.write_address, 1000);
        rst_b = 1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_b = 0;
        check("abort load", bus.load, 0);
        check("abort addr", bus.write_address, 0);
        check("abort data", bus.data_in, 0);
        check("abort busy", bus.busy, 0);
        check("abort frame_done", bus.frame_done, 0);
        check("abort pix_ready", bus.pix_ready, 1);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random traffic with clears on the small instance; a refused pixel is held.
        rst_b = 1;
        pv = 0; pd = 0; ps = 0;
        for (int t = 0; t < 3000; t++) begin
            logic c, cv;
            if (!(pv && !m_acc[1])) begin
                pv = ($urandom_range(0, 3) != 0);
                pd = 1'($urandom_range(0, 1));
                ps = ($urandom_range(0, 40) == 0);
            end
            c  = ($urandom_range(0, 60) == 0);
            cv = 1'($urandom_range(0, 1));
            step(pv, pd, ps, c, cv);
        end
        rst_b = 0;
        repeat (8) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_clear(1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pending writes 0", exp_q0.size(), 0);
        check("pending writes 1", exp_q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
